// File: rtl/bif_bus_responder.sv
// Bus-slave responder for the ND-100 style backplane.
// Decodes address cycles, claims memory accesses inside the address window,
// and runs a LREQ/LACK handshake to a local back end. Data cycles are answered
// with BDRY_n, read data or BERROR_n. Refresh cycles produce a one-cycle
// REFRESH pulse. Every output is a register.
module bif_bus_responder #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter int unsigned SIZE_LOG2 = 20,
  parameter int unsigned DRY_SETUP = 2,
  parameter int unsigned TOUT_CYC  = 64
) (
  input  logic        OSC,
  input  logic        CLEAR,
  input  logic        BAPR_n,
  input  logic        BDAP_n,
  input  logic        BINPUT_n,
  input  logic        BMEM_n,
  input  logic        BREF_n,
  input  logic [23:0] BD_IN_n,
  output logic [15:0] BD_OUT_n,
  output logic        BD_OE,
  output logic        BDRY_n,
  output logic        BERROR_n,
  output logic        LREQ,
  output logic        LWRITE,
  output logic [23:0] LADDR,
  output logic [15:0] LWDATA,
  input  logic [15:0] LRDATA,
  input  logic        LACK,
  input  logic        LPERR,
  output logic        REFRESH
);

  typedef enum logic [2:0] {
    IDLE, NOSEL, ADDR, ACCESS, SETUP, READY, ABORT
  } busStateT;

  busStateT state, stateNext;

  // Two-flop synchronizers, bit order: {apr, dap, input, mem, ref}
  logic [4:0] syncA, syncB;
  logic aprS, dapS, inputS, memS, refS;

  logic [7:0]  cnt, cntNext;
  logic        isWrite, isWriteNext;
  logic        errFlag, errNext;
  logic        abortPend, abortNext;
  logic        windowHit;

  logic [23:0] laddrNext;
  logic [15:0] lwdataNext, bdOutNext;
  logic        refreshNext, lreqNext, lwriteNext, bdOeNext, bdryNext, berrNext;

  assign {aprS, dapS, inputS, memS, refS} = syncB;

  // Only the bits above the window size take part in the decode
  assign windowHit = ((~BD_IN_n[23:SIZE_LOG2]) == BASE_ADDR[23:SIZE_LOG2]);

  // Next-state, datapath capture and next-output computation
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    isWriteNext = isWrite;
    errNext     = errFlag;
    abortNext   = abortPend;
    laddrNext   = LADDR;
    lwdataNext  = LWDATA;
    bdOutNext   = BD_OUT_n;
    refreshNext = 1'b0;

    unique case (state)
      IDLE: begin
        if (!aprS) begin
          if (!refS) begin
            refreshNext = 1'b1;
            stateNext   = NOSEL;
          end else if (!memS && windowHit) begin
            laddrNext = ~BD_IN_n;
            stateNext = ADDR;
          end else begin
            stateNext = NOSEL;
          end
        end
      end

      NOSEL: begin
        if (aprS) stateNext = IDLE;
      end

      ADDR: begin
        if (!dapS) begin
          isWriteNext = inputS;
          if (inputS) lwdataNext = ~BD_IN_n[15:0];
          cntNext   = '0;
          errNext   = 1'b0;
          abortNext = 1'b0;
          stateNext = ACCESS;
        end else if (aprS) begin
          stateNext = IDLE;
        end
      end

      ACCESS: begin
        // A master that drops BDAP_n early still gets its LREQ completed,
        // but the cycle ends in ABORT without any BDRY_n.
        abortNext = abortPend | dapS;
        if (LACK) begin
          bdOutNext = ~LRDATA;
          errNext   = LPERR;
          if (abortPend || dapS) begin
            stateNext = ABORT;
          end else if (isWrite) begin
            stateNext = READY;
          end else begin
            cntNext   = '0;
            stateNext = SETUP;
          end
        end else if (cnt == 8'(TOUT_CYC - 1)) begin
          errNext   = 1'b1;
          stateNext = (abortPend || dapS) ? ABORT : READY;
        end else begin
          cntNext = cnt + 8'd1;
        end
      end

      SETUP: begin
        if (cnt == 8'(DRY_SETUP - 1)) stateNext = READY;
        else                           cntNext   = cnt + 8'd1;
      end

      READY: begin
        if (dapS) stateNext = NOSEL;
      end

      ABORT: begin
        stateNext = NOSEL;
      end

      default: stateNext = IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it
    lreqNext   = (stateNext == ACCESS);
    lwriteNext = (stateNext == ACCESS) && isWriteNext;
    bdOeNext   = !isWriteNext &&
                 ((stateNext == SETUP) || ((stateNext == READY) && BD_OE));
    bdryNext   = !(stateNext == READY);
    berrNext   = !((stateNext == READY) && errNext);
  end

  // State, synchronizer and output registers with synchronous clear
  always_ff @(posedge OSC) begin
    if (CLEAR) begin
      syncA     <= '1;
      syncB     <= '1;
      state     <= IDLE;
      cnt       <= '0;
      isWrite   <= 1'b0;
      errFlag   <= 1'b0;
      abortPend <= 1'b0;
      LADDR     <= '0;
      LWDATA    <= '0;
      BD_OUT_n  <= '1;
      BD_OE     <= 1'b0;
      BDRY_n    <= 1'b1;
      BERROR_n  <= 1'b1;
      LREQ      <= 1'b0;
      LWRITE    <= 1'b0;
      REFRESH   <= 1'b0;
    end else begin
      syncA     <= {BAPR_n, BDAP_n, BINPUT_n, BMEM_n, BREF_n};
      syncB     <= syncA;
      state     <= stateNext;
      cnt       <= cntNext;
      isWrite   <= isWriteNext;
      errFlag   <= errNext;
      abortPend <= abortNext;
      LADDR     <= laddrNext;
      LWDATA    <= lwdataNext;
      BD_OUT_n  <= bdOutNext;
      BD_OE     <= bdOeNext;
      BDRY_n    <= bdryNext;
      BERROR_n  <= berrNext;
      LREQ      <= lreqNext;
      LWRITE    <= lwriteNext;
      REFRESH   <= refreshNext;
    end
  end

endmodule
